// File: rtl/mul_pkg.sv
// Shared types and default sizing for the shift-and-add multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    // Default operand width and the sizes derived from it.
    localparam int WIDTH_DEF = 4;
    localparam int PROD_W    = 2 * WIDTH_DEF;
    localparam int IDX_W     = $clog2(WIDTH_DEF);

endpackage

// File: rtl/shl_barrel.sv
// Logarithmic left shifter: SHAMT_W stages of 2:1 muxes, stage s shifts by 2**s.
// Latency: purely combinational.
// Backpressure: none.
module shl_barrel
    import mul_pkg::*;
#(
    parameter int DATA_W  = PROD_W,
    parameter int SHAMT_W = IDX_W
) (
    input  logic [DATA_W-1:0]  data_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [DATA_W-1:0]  data_out
);

    logic [DATA_W-1:0] stage [SHAMT_W+1];

    assign stage[0] = data_in;

    // Each stage conditionally applies one power-of-two shift.
    for (genvar s = 0; s < SHAMT_W; s++) begin : g_stage
        assign stage[s+1] = shamt[s] ? (stage[s] << (1 << s)) : stage[s];
    end

    assign data_out = stage[SHAMT_W];

endmodule

// File: rtl/shift_add_mul.sv
// Sequential unsigned shift-and-add multiplier, one multiplier bit per clock.
// Latency: start accepted at edge 0, done in cycle WIDTH+1 (or earlier with MUL_EARLY_EXIT_EN).
// Backpressure: start is only sampled while ready; start in RUN/DONE is ignored.
module shift_add_mul
    import mul_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int              PW       = 2 * WIDTH;
    localparam int              IW       = $clog2(WIDTH);
    localparam logic [IW-1:0]   LAST_IDX = IW'(WIDTH - 1);

    mul_state_t      state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [PW-1:0]    product_q, product_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [PW-1:0]    a_ext;
    logic [PW-1:0]    a_shl;
    logic [PW-1:0]    addend;
    logic [PW-1:0]    sum;
    logic             last_bit;
    logic             finish;
`ifdef MUL_EARLY_EXIT_EN
    logic             rest_zero;
`endif

    assign a_ext = {{WIDTH{1'b0}}, a_q};

    shl_barrel #(
        .DATA_W  (PW),
        .SHAMT_W (IW)
    ) u_shl (
        .data_in  (a_ext),
        .shamt    (idx_q),
        .data_out (a_shl)
    );

    // Partial-product add for the current multiplier bit and the RUN exit test.
    always_comb begin
        addend   = b_q[idx_q] ? a_shl : '0;
        sum      = acc_q + addend;
        last_bit = (idx_q == LAST_IDX);
`ifdef MUL_EARLY_EXIT_EN
        // Nothing left to add once every multiplier bit above idx is zero.
        rest_zero = (((b_q >> idx_q) >> 1) == '0);
        finish    = last_bit | rest_zero;
`else
        finish    = last_bit;
`endif
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = sum;
                idx_d = idx_q + IW'(1);
                if (finish) begin
                    product_d = sum;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d == IDLE);
        busy_d  = (state_d == RUN);
        done_d  = (state_d == DONE);
    end

    // State, datapath and output registers; reset aborts any multiply in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            idx_q     <= '0;
            product_q <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            product_q <= product_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign ready   = ready_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_shift_add_mul.sv
// Directed and sweep checks of shift_add_mul at WIDTH=4.
// Latency: expectations cover done/ready cycle positions and accept-to-accept spacing.
// Backpressure: exercises ignored start pulses during RUN and DONE.
module tb_shift_add_mul;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           ready;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int  n_vec = 0;
    int  n_err = 0;
    time last_done_t = 0;

    always #5 clk = ~clk;

    shift_add_mul #(.WIDTH(W)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Cycle in which done is expected, counted from the accepting edge.
    function automatic int exp_done_cyc(input logic [W-1:0] bv);
`ifdef MUL_EARLY_EXIT_EN
        int hb;
        hb = 0;
        for (int i = 0; i < W; i++) if (bv[i]) hb = i;
        return hb + 2;
`else
        return W + 1;
`endif
    endfunction

    // Issue one multiply at a negedge, then follow it until ready returns.
    task automatic run_mul(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                           input logic [2*W-1:0] exp_p, input int exp_dc,
                           input logic [31:0] pulse_mask, input bit chk_gap);
        int dcyc, rcyc, dcnt, bcnt;
        dcyc = 0; rcyc = 0; dcnt = 0; bcnt = 0;
        chk({tag, ".ready_pre"}, ready, 1);
        start = 1'b1; a = ta; b = tb;
        @(posedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = (c < 32) ? pulse_mask[c] : 1'b0;
            a     = start ? 4'd1 : 4'd0;
            b     = start ? 4'd1 : 4'd0;
            if (busy) bcnt++;
            if (done) begin
                dcnt++;
                if (dcyc == 0) begin
                    dcyc = c;
                    chk({tag, ".product"}, product, exp_p);
`ifndef MUL_EARLY_EXIT_EN
                    if (chk_gap && last_done_t != 0)
                        chk({tag, ".done_gap"}, 32'(($time - last_done_t) / 10), W + 2);
`endif
                    last_done_t = $time;
                end
            end
            if (dcyc != 0 && ready) begin
                rcyc = c;
                break;
            end
        end
        start = 1'b0;
        chk({tag, ".ready_seen"}, (rcyc != 0), 1);
        chk({tag, ".done_cyc"}, dcyc, exp_dc);
        chk({tag, ".done_cnt"}, dcnt, 1);
        chk({tag, ".busy_cyc"}, bcnt, exp_dc - 1);
        chk({tag, ".ready_cyc"}, rcyc, exp_dc + 1);
        chk({tag, ".product_hold"}, product, exp_p);
    endtask

    initial begin
        int dc, dcnt;
        logic [2*W-1:0] p;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        #12;
        chk("rst.ready", ready, 1);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.product", product, 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        run_mul("m15x15", 4'd15, 4'd15, 8'd225, 5, 0, 0);
`ifdef MUL_EARLY_EXIT_EN
        dc = 3;
`else
        dc = 5;
`endif
        run_mul("m6x3", 4'd6, 4'd3, 8'd18, dc, 0, 0);
`ifdef MUL_EARLY_EXIT_EN
        dc = 2;
`else
        dc = 5;
`endif
        run_mul("m9x0", 4'd9, 4'd0, 8'd0, dc, 0, 0);
`ifdef MUL_EARLY_EXIT_EN
        dc = 4;
`else
        dc = 5;
`endif
        // start pulses in cycle 2 (RUN) and in the DONE cycle must be ignored.
        run_mul("ign5x5", 4'd5, 4'd5, 8'd25, dc, (32'd1 << 2) | (32'd1 << dc), 0);

        // Reset in the middle of RUN.
        chk("abort.ready_pre", ready, 1);
        start = 1'b1; a = 4'd7; b = 4'd7;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        chk("abort.busy_c1", busy, 1);
        @(negedge clk); rst_n = 1'b0;
        #1;
        chk("abort.ready", ready, 1);
        chk("abort.busy", busy, 0);
        chk("abort.done", done, 0);
        chk("abort.product", product, 0);
        dcnt = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("abort.no_done", dcnt, 0);
        chk("abort.product_idle", product, 0);
`ifdef MUL_EARLY_EXIT_EN
        dc = 3;
`else
        dc = 5;
`endif
        run_mul("m2x3", 4'd2, 4'd3, 8'd6, dc, 0, 0);

        // Exhaustive back-to-back sweep.
        last_done_t = 0;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                p = 8'(ia * ib);
                run_mul("sweep", 4'(ia), 4'(ib), p, exp_done_cyc(4'(ib)), 0, 1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
